wb_burst_reader: RTL and testbench

- Wishbone classic initiator that fetches a run of consecutive 32-bit words from a Wishbone responder. The intended target is the SDRAM-backed user memory window at 0x3800_0000.
- Accepts a command (start address, word count) and issues one single read per word. Returned words are buffered in an internal FIFO and presented on a valid/ready stream.
- Sits between user-project compute logic (e.g. a FIR or matmul engine) and the memory responder. Replaces firmware-driven word-by-word loads.

---
 rtl/wb_burst_reader.sv | 212 +++++++++++++++++++++
 tb/tb_wb_burst_reader.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_burst_reader.sv
// wb_burst_reader: Wishbone classic initiator that reads a run of consecutive
// 32-bit words (one single read per word, at most one outstanding) and
// streams them out through a small read-data FIFO on a valid/ready port.
//
// Optional build macro: WB_TIMEOUT_EN
//   defined   -> an ack watchdog aborts a read after TIMEOUT_CYC cycles in
//                WAIT_ACK, pulses err and abandons the rest of the command.
//   undefined -> WAIT_ACK waits indefinitely and err is tied low.

module wb_burst_reader #(
  parameter int LEN_W       = 8,
  parameter int FIFO_DEPTH  = 8,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic             wb_clk_i,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [31:0]      cmd_addr,
  input  logic [LEN_W-1:0] cmd_len,
  output logic             wbm_cyc_o,
  output logic             wbm_stb_o,
  output logic             wbm_we_o,
  output logic [3:0]       wbm_sel_o,
  output logic [31:0]      wbm_adr_o,
  input  logic [31:0]      wbm_dat_i,
  input  logic             wbm_ack_i,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Elaboration-time sanity check of the configuration.
  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) || (TIMEOUT_CYC < 1)) begin : g_param_check
    $error("wb_burst_reader: FIFO_DEPTH must be a power of 2 >= 2 and TIMEOUT_CYC >= 1");
  end

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_ACK = 2'd2,
    GAP      = 2'd3
  } state_t;

  state_t             state_r, state_nxt;
  logic               cyc_r, cyc_nxt;
  logic [31:0]        adr_r, adr_nxt;
  logic [LEN_W-1:0]   rem_r, rem_nxt;
  logic               done_r, done_nxt;
  logic               err_r, err_nxt;

  logic [31:0]        mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_r, rd_ptr_r;
  logic [CNT_W-1:0]   count_r;

  logic               push_s;
  logic               pop_s;
  logic               slot_free_s;
  logic               tmo_hit_s;

  // Only an ack seen while our strobe is up counts; stray acks are ignored.
  assign push_s      = (state_r == WAIT_ACK) && cyc_r && wbm_ack_i;
  assign pop_s       = out_valid && out_ready;
  // A slot is guaranteed if the FIFO is not full or the head leaves this cycle.
  assign slot_free_s = (count_r < CNT_W'(FIFO_DEPTH)) || pop_s;

`ifdef WB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0] tmo_r;

  // Ack watchdog: zero outside WAIT_ACK, so it always starts from 0 on entry.
  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      tmo_r <= TMO_W'(0);
    end else if (state_r != WAIT_ACK) begin
      tmo_r <= TMO_W'(0);
    end else begin
      tmo_r <= tmo_r + TMO_W'(1);
    end
  end

  assign tmo_hit_s = (tmo_r == TMO_W'(TIMEOUT_CYC - 1));
`else
  assign tmo_hit_s = 1'b0;
`endif

  // Next-state and next-output decode for the bus sequencer.
  always_comb begin
    state_nxt = state_r;
    cyc_nxt   = cyc_r;
    adr_nxt   = adr_r;
    rem_nxt   = rem_r;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;
    case (state_r)
      IDLE: begin
        cyc_nxt = 1'b0;
        if (cmd_valid) begin
          adr_nxt = {cmd_addr[31:2], 2'b00};
          rem_nxt = cmd_len;
          if (cmd_len == LEN_W'(0)) begin
            done_nxt = 1'b1;
          end else begin
            state_nxt = ISSUE;
          end
        end else begin
          state_nxt = IDLE;
        end
      end
      ISSUE: begin
        if (slot_free_s) begin
          cyc_nxt   = 1'b1;
          state_nxt = WAIT_ACK;
        end else begin
          cyc_nxt   = 1'b0;
        end
      end
      WAIT_ACK: begin
        if (push_s) begin
          cyc_nxt = 1'b0;
          adr_nxt = adr_r + 32'd4;
          rem_nxt = rem_r - LEN_W'(1);
          if (rem_r == LEN_W'(1)) begin
            done_nxt  = 1'b1;
            state_nxt = IDLE;
          end else begin
            state_nxt = GAP;
          end
        end else if (tmo_hit_s) begin
          cyc_nxt   = 1'b0;
          err_nxt   = 1'b1;
          state_nxt = IDLE;
        end else begin
          cyc_nxt   = 1'b1;
        end
      end
      GAP: begin
        cyc_nxt   = 1'b0;
        state_nxt = ISSUE;
      end
      default: begin
        cyc_nxt   = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  // Sequencer state and registered bus/status outputs.
  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      cyc_r   <= 1'b0;
      adr_r   <= 32'd0;
      rem_r   <= LEN_W'(0);
      done_r  <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_nxt;
      cyc_r   <= cyc_nxt;
      adr_r   <= adr_nxt;
      rem_r   <= rem_nxt;
      done_r  <= done_nxt;
      err_r   <= err_nxt;
    end
  end

  // Read-data FIFO storage, pointers and occupancy.
  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= PTR_W'(0);
      rd_ptr_r <= PTR_W'(0);
      count_r  <= CNT_W'(0);
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= 32'd0;
      end
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= wbm_dat_i;
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign cmd_ready = (state_r == IDLE);
  assign busy      = (state_r != IDLE);
  assign done      = done_r;
  assign err       = err_r;

  assign wbm_cyc_o = cyc_r;
  assign wbm_stb_o = cyc_r;
  assign wbm_we_o  = 1'b0;
  assign wbm_sel_o = 4'hF;
  assign wbm_adr_o = adr_r;

  assign out_valid = (count_r != CNT_W'(0));
  assign out_data  = mem_r[rd_ptr_r];

endmodule

// File: tb/tb_wb_burst_reader.sv
// Self-checking bench for wb_burst_reader: a latency-3 Wishbone responder
// model returns address-derived data; expected addresses and words are
// queued when each command is sent and compared as the DUT produces them.

module tb_wb_burst_reader;

  localparam int LEN_W       = 8;
  localparam int FIFO_DEPTH  = 8;
  localparam int TIMEOUT_CYC = 64;
  localparam int ACK_LAT     = 3;

  logic             wb_clk_i = 1'b0;
  logic             rst_n;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [31:0]      cmd_addr;
  logic [LEN_W-1:0] cmd_len;
  logic             wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [3:0]       wbm_sel_o;
  logic [31:0]      wbm_adr_o;
  logic [31:0]      wbm_dat_i = 32'd0;
  logic             wbm_ack_i = 1'b0;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_data;
  logic             busy, done, err;

  wb_burst_reader #(
    .LEN_W(LEN_W), .FIFO_DEPTH(FIFO_DEPTH), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .wb_clk_i(wb_clk_i), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
    .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o),
    .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .done(done), .err(err)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_adr_q[$];
  logic [31:0] exp_dat_q[$];
  int acks_total = 0;
  int ack_limit  = 32'h7FFF_FFFF;
  int resp_wait  = 0;
  int done_cnt = 0, err_cnt = 0, pops = 0, stb_rises = 0;
  int cyc_num = 0, stb_rise_cyc = 0, err_cyc = 0;
  logic stb_prev = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_F00D;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Responder model: ack ACK_LAT cycles after the strobe, unless held off by ack_limit.
  always @(negedge wb_clk_i) begin
    if (!rst_n) begin
      wbm_ack_i = 1'b0;
      resp_wait = 0;
    end else if (wbm_cyc_o && wbm_stb_o && !wbm_ack_i) begin
      resp_wait++;
      if (resp_wait >= ACK_LAT && acks_total < ack_limit) begin
        wbm_ack_i = 1'b1;
        wbm_dat_i = mem_word(wbm_adr_o);
        acks_total++;
        resp_wait = 0;
        check("we_low", {31'd0, wbm_we_o}, 32'd0);
        check("sel_all", {28'd0, wbm_sel_o}, 32'h0000_000F);
        check("adr_expected", 32'(exp_adr_q.size() > 0), 32'd1);
        if (exp_adr_q.size() > 0) check("wbm_adr", wbm_adr_o, exp_adr_q.pop_front());
      end
    end else begin
      wbm_ack_i = 1'b0;
      resp_wait = 0;
    end
  end

  // Stream consumer / event monitor: scoreboard pops and pulse counting.
  always @(negedge wb_clk_i) begin
    cyc_num++;
    if (rst_n) begin
      if (done) done_cnt++;
      if (err) begin
        err_cnt++;
        err_cyc = cyc_num;
      end
      if (wbm_stb_o && !stb_prev) begin
        stb_rises++;
        stb_rise_cyc = cyc_num;
      end
      if (out_valid && out_ready) begin
        pops++;
        check("pop_expected", 32'(exp_dat_q.size() > 0), 32'd1);
        if (exp_dat_q.size() > 0) check("out_data", out_data, exp_dat_q.pop_front());
      end
    end
    stb_prev = wbm_stb_o;
  end

  task automatic tick();
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic send_cmd(input logic [31:0] a, input int n);
    int guard = 0;
    while (!cmd_ready && guard < 300) begin
      tick();
      guard++;
    end
    check("cmd_ready_before_send", {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_len   = LEN_W'(n);
    for (int i = 0; i < n; i++) begin
      logic [31:0] wa;
      wa = {a[31:2], 2'b00} + 32'(4 * i);
      exp_adr_q.push_back(wa);
      exp_dat_q.push_back(mem_word(wa));
    end
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int guard = 0;
    while (busy && guard < budget) begin
      tick();
      guard++;
    end
    check(tag, {31'd0, busy}, 32'd0);
    tick();
    tick();
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int guard = 0;
    while ((exp_dat_q.size() > 0 || out_valid) && guard < budget) begin
      tick();
      guard++;
    end
    check(tag, 32'(exp_dat_q.size()), 32'd0);
  endtask

  task automatic wait_acks(input string tag, input int target, input int budget);
    int guard = 0;
    while (acks_total < target && guard < budget) begin
      tick();
      guard++;
    end
    check(tag, 32'(acks_total), 32'(target));
  endtask

  initial begin
    int a0, d0, s0, p0, e0, guard;
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_addr  = 32'd0;
    cmd_len   = '0;
    out_ready = 1'b0;
    repeat (3) tick();

    // Reset state
    check("reset_flags", {24'd0, cmd_ready, wbm_cyc_o, wbm_stb_o, wbm_we_o, out_valid, busy, done, err},
          32'h0000_0080);
    check("reset_adr", wbm_adr_o, 32'd0);
    check("reset_out_data", out_data, 32'd0);
    rst_n = 1'b1;
    tick();

    // Basic 4-word burst with the consumer always ready
    out_ready = 1'b1;
    a0 = acks_total; d0 = done_cnt;
    send_cmd(32'h3800_0000, 4);
    wait_idle("basic_idle", 200);
    wait_drain("basic_drain", 50);
    check("basic_reads", 32'(acks_total - a0), 32'd4);
    check("basic_done_once", 32'(done_cnt - d0), 32'd1);

    // Zero-length command: done next cycle, no bus traffic
    s0 = stb_rises; d0 = done_cnt;
    send_cmd(32'h3800_0100, 0);
    check("zl_done_pulse", {31'd0, done}, 32'd1);
    check("zl_not_busy", {31'd0, busy}, 32'd0);
    tick();
    check("zl_done_low", {31'd0, done}, 32'd0);
    repeat (5) tick();
    check("zl_no_cyc", 32'(stb_rises - s0), 32'd0);
    check("zl_done_once", 32'(done_cnt - d0), 32'd1);

    // Misaligned start address is word-aligned
    send_cmd(32'h3800_0013, 1);
    wait_idle("mis_idle", 100);
    wait_drain("mis_drain", 50);

    // Address wraps modulo 2^32
    send_cmd(32'hFFFF_FFF8, 3);
    wait_idle("wrap_idle", 200);
    wait_drain("wrap_drain", 50);

    // Backpressure: FIFO fills at 8 reads, more reads only as slots open
    out_ready = 1'b0;
    a0 = acks_total; p0 = pops;
    send_cmd(32'h3800_1000, 12);
    wait_acks("bp_first8", a0 + 8, 500);
    repeat (20) tick();
    check("bp_reads_held", 32'(acks_total - a0), 32'd8);
    check("bp_cyc_low", {31'd0, wbm_cyc_o}, 32'd0);
    check("bp_busy", {31'd0, busy}, 32'd1);
    check("bp_full_valid", {31'd0, out_valid}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end
    check("bp_four_pops", 32'(pops - p0), 32'd4);
    wait_acks("bp_all12", a0 + 12, 500);
    wait_idle("bp_idle", 200);
    repeat (10) tick();
    check("bp_reads_total", 32'(acks_total - a0), 32'd12);
    out_ready = 1'b1;
    wait_drain("bp_drain", 100);
    check("bp_pops_total", 32'(pops - p0), 32'd12);

    // Mid-burst asynchronous reset while word 2 of 5 is strobed
    a0 = acks_total;
    send_cmd(32'h3800_2000, 5);
    guard = 0;
    while (!(acks_total - a0 == 1 && wbm_stb_o) && guard < 200) begin
      tick();
      guard++;
    end
    check("mr_reached_word2", {31'd0, wbm_stb_o}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mr_cyc_async", {31'd0, wbm_cyc_o}, 32'd0);
    check("mr_stb_async", {31'd0, wbm_stb_o}, 32'd0);
    check("mr_out_valid", {31'd0, out_valid}, 32'd0);
    check("mr_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    exp_adr_q.delete();
    exp_dat_q.delete();
    tick();
    rst_n = 1'b1;
    tick();
    check("mr_ready_after", {31'd0, cmd_ready}, 32'd1);
    a0 = acks_total; d0 = done_cnt;
    send_cmd(32'h3800_2100, 2);
    wait_idle("mr_next_idle", 200);
    wait_drain("mr_next_drain", 50);
    check("mr_next_reads", 32'(acks_total - a0), 32'd2);
    check("mr_next_done", 32'(done_cnt - d0), 32'd1);

`ifdef WB_TIMEOUT_EN
    // Watchdog: word 3 of 5 never acked
    out_ready = 1'b0;
    d0 = done_cnt; e0 = err_cnt; p0 = pops;
    ack_limit = acks_total + 2;
    send_cmd(32'h3800_3000, 5);
    guard = 0;
    while (err_cnt == e0 && guard < 500) begin
      tick();
      guard++;
    end
    repeat (2) tick();
    check("to_err_once", 32'(err_cnt - e0), 32'd1);
    check("to_latency", 32'(err_cyc - stb_rise_cyc), 32'(TIMEOUT_CYC));
    check("to_no_done", 32'(done_cnt - d0), 32'd0);
    check("to_not_busy", {31'd0, busy}, 32'd0);
    check("to_words_kept", {31'd0, out_valid}, 32'd1);
    ack_limit = 32'h7FFF_FFFF;
    exp_adr_q.delete();
    while (exp_dat_q.size() > 2) void'(exp_dat_q.pop_back());
    out_ready = 1'b1;
    wait_drain("to_drain", 50);
    check("to_two_words", 32'(pops - p0), 32'd2);
`else
    check("err_never", 32'(err_cnt), 32'd0);
`endif

    check("adr_q_empty", 32'(exp_adr_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
